// File: rtl/rc4_stream_pkg.sv
// Shared types and width helpers for the RC4 keystream consumer blocks.
package rc4_stream_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream byte FIFO; a push while full is taken only when a pop frees a slot the same cycle.
module rc4_ks_fifo
  import rc4_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  byte_t push_data,
  output logic  full,
  output logic  empty,
  output byte_t head
);

  localparam int AW = clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs plaintext with buffered RC4 keystream onto a registered valid/ready output.
// Optional RC4-drop[n] discard of the first keystream bytes via macro RC4_DROP_EN.
module rc4_xor_stream
  import rc4_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32,
  parameter int DROP_BYTES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  input  logic             pt_valid,
  input  logic [7:0]       pt_data,
  output logic             pt_ready,
  output logic             ct_valid,
  output logic [7:0]       ct_data,
  input  logic             ct_ready,
  output logic             ks_overflow,
  output logic [CNT_W-1:0] byte_count
);

  logic  dropping;
  logic  push;
  logic  fire;
  logic  fifo_full;
  logic  fifo_empty;
  byte_t fifo_head;

`ifdef RC4_DROP_EN
  localparam int DROP_W = (clog2(DROP_BYTES + 1) > 0) ? clog2(DROP_BYTES + 1) : 1;

  logic [DROP_W-1:0] drop_cnt;

  // Saturates at DROP_BYTES, after which every keystream byte is stored.
  assign dropping = (drop_cnt != DROP_W'(DROP_BYTES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      drop_cnt <= '0;
    else if (ks_valid && dropping) drop_cnt <= drop_cnt + DROP_W'(1);
  end
`else
  assign dropping = 1'b0;
`endif

  assign push     = ks_valid && !dropping;
  assign pt_ready = !fifo_empty && (!ct_valid || ct_ready);
  assign fire     = pt_valid && pt_ready;

  rc4_ks_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (fire),
    .push_data(ks_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ct_valid    <= 1'b0;
      ct_data     <= '0;
      byte_count  <= '0;
      ks_overflow <= 1'b0;
    end else begin
      if (fire) begin
        ct_data    <= pt_data ^ fifo_head;
        ct_valid   <= 1'b1;
        byte_count <= byte_count + CNT_W'(1);
      end else if (ct_ready) begin
        ct_valid <= 1'b0;
      end
      // The rc4 core cannot be stalled, so a rejected push is a lost byte.
      if (push && fifo_full && !fire) ks_overflow <= 1'b1;
    end
  end

endmodule
